// File: rtl/button_event_arbiter_pkg.sv
// Shared UI package for the parameter-selection front end.
// - evt_code_t: event codes, identical to the selector FSM's *_PRESSED codes.
// - btn_state_t: per-button press/repeat FSM states.
// - NUM_BTNS / REPEAT_MASK: button count and which buttons auto-repeat.
// - cnt_width(): counter width wide enough for the largest timing parameter.
package button_event_arbiter_pkg;

    typedef enum logic [2:0] {
        EVT_NONE = 3'd0,
        EVT_UP   = 3'd1,
        EVT_DOWN = 3'd2,
        EVT_NEXT = 3'd3,
        EVT_SET  = 3'd4
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } btn_state_t;

    // Button index order is {set, next, down, up}; index i maps to code i+1.
    localparam int NUM_BTNS = 4;

    // Only up (bit 0) and down (bit 1) auto-repeat.
    localparam logic [NUM_BTNS-1:0] REPEAT_MASK = 4'b0011;

    // One extra bit over $clog2 so the terminal compare can never wrap.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

    function automatic evt_code_t idx_to_code(input int idx);
        return evt_code_t'(3'(idx + 1));
    endfunction

endpackage

// File: rtl/button_event_arbiter_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stable-count debouncer for one
// raw pushbutton.
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   raw   in   raw asynchronous button level
//   held  out  debounced level
module button_debouncer
    import button_event_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int CW              = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic held
);

    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt holds the number of consecutive mismatched cycles already seen;
    // the cycle that finds cnt==LAST still mismatched is the accepting one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            held  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == held) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                held <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: debounces up/down/next/set, turns presses into single
// events with auto-repeat on held up/down, and hands one event at a time to
// the selector over a valid/ready handshake.
// Ports:
//   clk_65mhz   in   system clock
//   rst         in   synchronous active-high reset
//   btn_*       in   raw asynchronous buttons
//   evt_ready   in   consumer accepts the presented event
//   evt_valid   out  an event is presented
//   evt_code    out  1=UP 2=DOWN 3=NEXT 4=SET, 0 while !evt_valid
//   evt_repeat  out  event came from auto-repeat
//   held        out  debounced levels {set,next,down,up}
//   drop_pulse  out  a request merged into an event already waiting
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65000,
    parameter int REPEAT_DELAY    = 32500000,
    parameter int REPEAT_PERIOD   = 6500000
) (
    input  logic       clk_65mhz,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic       btn_set,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_repeat,
    output logic [3:0] held,
    output logic       drop_pulse
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);

    logic [NUM_BTNS-1:0] raw;
    assign raw = {btn_set, btn_next, btn_down, btn_up};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CW              (CW)
        ) u_db (
            .clk  (clk_65mhz),
            .rst  (rst),
            .raw  (raw[g]),
            .held (held[g])
        );
    end

    btn_state_t [NUM_BTNS-1:0]         state, state_n;
    logic       [NUM_BTNS-1:0][CW-1:0] rcnt, rcnt_n;
    logic       [NUM_BTNS-1:0]         req, req_rpt;
    logic       [NUM_BTNS-1:0]         pend, pend_n, rpt, rpt_n;
    logic       [NUM_BTNS-1:0]         take, in_flight, merge;
    logic                              load, sel_vld, sel_rpt;
    evt_code_t                         sel_code;

    // Press/repeat FSMs: a request is raised in the cycle the transition is made.
    always_comb begin
        for (int i = 0; i < NUM_BTNS; i++) begin
            state_n[i] = state[i];
            rcnt_n[i]  = rcnt[i];
            req[i]     = 1'b0;
            req_rpt[i] = 1'b0;
            if (!held[i]) begin
                state_n[i] = ST_IDLE;
                rcnt_n[i]  = '0;
            end else begin
                case (state[i])
                    ST_IDLE: begin
                        state_n[i] = ST_HOLD;
                        rcnt_n[i]  = '0;
                        req[i]     = 1'b1;
                    end
                    ST_HOLD: begin
                        // next/set park here until release
                        if (REPEAT_MASK[i]) begin
                            if (rcnt[i] == DLY_LAST) begin
                                state_n[i] = ST_REPEAT;
                                rcnt_n[i]  = '0;
                                req[i]     = 1'b1;
                                req_rpt[i] = 1'b1;
                            end else begin
                                rcnt_n[i] = rcnt[i] + 1'b1;
                            end
                        end
                    end
                    ST_REPEAT: begin
                        if (rcnt[i] == PER_LAST) begin
                            rcnt_n[i]  = '0;
                            req[i]     = 1'b1;
                            req_rpt[i] = 1'b1;
                        end else begin
                            rcnt_n[i] = rcnt[i] + 1'b1;
                        end
                    end
                    default: state_n[i] = ST_IDLE;
                endcase
            end
        end
    end

    // Arbiter and pending bits. A stalled presented event counts as still
    // pending for its button, so a second press while stalled merges into it
    // rather than queueing a duplicate behind it.
    always_comb begin
        load     = !evt_valid || evt_ready;
        take     = '0;
        sel_vld  = 1'b0;
        sel_rpt  = 1'b0;
        sel_code = EVT_NONE;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pend[i] && !sel_vld) begin
                sel_vld  = 1'b1;
                sel_rpt  = rpt[i];
                sel_code = idx_to_code(i);
                take[i]  = load;
            end
        end
        for (int i = 0; i < NUM_BTNS; i++) begin
            in_flight[i] = evt_valid && !evt_ready && (evt_code == idx_to_code(i));
            merge[i]     = req[i] && ((pend[i] && !take[i]) || in_flight[i]);
            // a request in the consume cycle keeps the bit set
            pend_n[i]    = (pend[i] && !take[i]) || (req[i] && !in_flight[i]);
            rpt_n[i]     = (req[i] && !in_flight[i]) ? req_rpt[i] : rpt[i];
        end
    end

    always_ff @(posedge clk_65mhz) begin
        if (rst) begin
            state      <= {NUM_BTNS{ST_IDLE}};
            rcnt       <= '0;
            pend       <= '0;
            rpt        <= '0;
            evt_valid  <= 1'b0;
            evt_code   <= EVT_NONE;
            evt_repeat <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            state      <= state_n;
            rcnt       <= rcnt_n;
            pend       <= pend_n;
            rpt        <= rpt_n;
            drop_pulse <= |merge;
            if (load) begin
                evt_valid  <= sel_vld;
                evt_code   <= sel_code;
                evt_repeat <= sel_rpt;
            end
        end
    end

endmodule
